// File: rtl/stack_datapath.sv
// Stack-processor execution datapath: LIFO operand stack, two operand
// registers (temp1/temp2) and a combinational ALU fed from those registers.
module stack_datapath #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_pilha,
  input  logic             wren,
  input  logic             controle_pilha,
  input  logic             load_temp1,
  input  logic             load_temp2,
  input  logic [WIDTH-1:0] din_UC,
  input  logic [4:0]       opcode,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] alu_out,
  output logic             full,
  output logic             empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int SP_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SP_W-1:0]  sp;
  logic [SP_W-1:0]  sp_dec;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] temp1;
  logic [WIDTH-1:0] temp2;
  logic [WIDTH-1:0] push_data;
  logic             push_ok;
  logic             pop_op;

  function automatic logic [WIDTH-1:0] alu_op(input logic [4:0]       op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      5'b00000: r = a;
      5'b00001: r = b;
      5'b00100: r = a + b;
      5'b00101: r = a - b;
      5'b00110: r = a & b;
      5'b00111: r = a | b;
      5'b01000: r = a ^ b;
      5'b01001: r = ~a;
      5'b01010: r = {a[WIDTH-2:0], 1'b0};
      5'b01011: r = {1'b0, a[WIDTH-1:1]};
      default:  r = '0;
    endcase
    return r;
  endfunction

  assign sp_dec    = sp - SP_W'(1);
  assign top_idx   = sp_dec[AW-1:0];
  assign full      = (sp == SP_W'(DEPTH));
  assign empty     = (sp == '0);
  assign tos       = empty ? '0 : mem[top_idx];
  assign alu_out   = alu_op(opcode, temp1, temp2);
  assign push_data = controle_pilha ? alu_out : din_UC;
  assign push_ok   = en_pilha && wren && !full;
  assign pop_op    = en_pilha && !wren;

  // Temps capture the pre-edge dout, so a pop and a load in one cycle load the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp    <= '0;
      dout  <= '0;
      temp1 <= '0;
      temp2 <= '0;
    end else begin
      if (load_temp1) temp1 <= dout;
      if (load_temp2) temp2 <= dout;
      if (push_ok) begin
        sp <= sp + SP_W'(1);
      end else if (pop_op) begin
        if (!empty) begin
          dout <= mem[top_idx];
          sp   <= sp_dec;
        end else begin
          dout <= '0;
        end
      end
    end
  end

  // Stack storage is not reset; SP alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[sp[AW-1:0]] <= push_data;
  end

endmodule

// File: tb/tb_stack_datapath.sv
// Directed bench for stack_datapath: queue-based reference model checked every
// cycle, plus hand-computed literal expectations along the directed sequence.
module tb_stack_datapath;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en_pilha = 1'b0;
  logic             wren = 1'b0;
  logic             controle_pilha = 1'b0;
  logic             load_temp1 = 1'b0;
  logic             load_temp2 = 1'b0;
  logic [WIDTH-1:0] din_UC = '0;
  logic [4:0]       opcode = 5'b00100;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] alu_out;
  logic             full;
  logic             empty;

  int checks = 0;
  int failures = 0;

  stack_datapath #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .en_pilha       (en_pilha),
    .wren           (wren),
    .controle_pilha (controle_pilha),
    .load_temp1     (load_temp1),
    .load_temp2     (load_temp2),
    .din_UC         (din_UC),
    .opcode         (opcode),
    .dout           (dout),
    .tos            (tos),
    .alu_out        (alu_out),
    .full           (full),
    .empty          (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain queue for the stack, table lookup for the ALU.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout = '0;
  logic [WIDTH-1:0] m_t1 = '0;
  logic [WIDTH-1:0] m_t2 = '0;
  logic [WIDTH-1:0] m_old;
  logic [WIDTH-1:0] m_alu;

  function automatic logic [WIDTH-1:0] model_alu(input logic [4:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    int unsigned ua, ub;
    ua = a;
    ub = b;
    case (op)
      5'd0:    return a;
      5'd1:    return b;
      5'd4:    return WIDTH'((ua + ub) % 65536);
      5'd5:    return WIDTH'((ua + 65536 - ub) % 65536);
      5'd6:    return a & b;
      5'd7:    return a | b;
      5'd8:    return a ^ b;
      5'd9:    return WIDTH'(65535 - ua);
      5'd10:   return WIDTH'((ua * 2) % 65536);
      5'd11:   return WIDTH'(ua / 2);
      default: return '0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_dout = '0;
      m_t1   = '0;
      m_t2   = '0;
    end else begin
      m_old = m_dout;
      m_alu = model_alu(opcode, m_t1, m_t2);
      if (en_pilha) begin
        if (wren) begin
          if (q.size() < DEPTH) q.push_back(controle_pilha ? m_alu : din_UC);
        end else begin
          if (q.size() > 0) m_dout = q.pop_back();
          else m_dout = '0;
        end
      end
      if (load_temp1) m_t1 = m_old;
      if (load_temp2) m_t2 = m_old;
    end
  end

  always @(negedge clk) begin
    chk("cyc_dout", dout, m_dout);
    chk("cyc_tos", tos, (q.size() > 0) ? q[$] : '0);
    chk("cyc_alu", alu_out, model_alu(opcode, m_t1, m_t2));
    chk("cyc_full", {15'd0, full}, {15'd0, q.size() == DEPTH});
    chk("cyc_empty", {15'd0, empty}, {15'd0, q.size() == 0});
  end

  task automatic step(input logic en, input logic wr, input logic ctl,
                      input logic l1, input logic l2,
                      input logic [WIDTH-1:0] d, input logic [4:0] op);
    en_pilha = en; wren = wr; controle_pilha = ctl;
    load_temp1 = l1; load_temp2 = l2; din_UC = d; opcode = op;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1'b0;
    #7;
    chk("rst_dout", dout, 16'h0000);
    chk("rst_tos", tos, 16'h0000);
    chk("rst_empty", {15'd0, empty}, 16'h0001);
    chk("rst_full", {15'd0, full}, 16'h0000);
    chk("rst_alu", alu_out, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b1;

    step(1, 1, 0, 0, 0, 16'h1234, 5'd4);
    chk("push_tos", tos, 16'h1234);
    step(1, 0, 0, 0, 0, 16'h0000, 5'd4);
    chk("pop_dout", dout, 16'h1234);
    chk("pop_empty", {15'd0, empty}, 16'h0001);
    step(0, 0, 0, 1, 1, 16'h0000, 5'd4);
    chk("alu_add", alu_out, 16'h2468);
    opcode = 5'd5; #1;
    chk("alu_sub", alu_out, 16'h0000);
    step(1, 1, 1, 0, 0, 16'h5555, 5'd4);
    chk("alu_push_tos", tos, 16'h2468);
    step(1, 0, 0, 0, 0, 16'h0000, 5'd4);
    chk("alu_pop_dout", dout, 16'h2468);

    for (int i = 0; i <= DEPTH; i++) step(1, 1, 0, 0, 0, WIDTH'(16'h0100 + i), 5'd4);
    chk("full_flag", {15'd0, full}, 16'h0001);
    chk("full_tos", tos, 16'h010F);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 0, 16'h0000, 5'd4);
    chk("drain_dout", dout, 16'h0100);
    step(1, 0, 0, 0, 0, 16'h0000, 5'd4);
    chk("pop_empty_dout", dout, 16'h0000);
    chk("pop_empty_flag", {15'd0, empty}, 16'h0001);
    step(0, 1, 0, 0, 0, 16'hDEAD, 5'd4);
    chk("disabled_hold", {15'd0, empty}, 16'h0001);

    step(1, 1, 0, 0, 0, 16'h0001, 5'd4);
    step(1, 1, 0, 0, 0, 16'hFFFF, 5'd4);
    step(1, 0, 0, 0, 0, 16'h0000, 5'd4);
    step(1, 0, 0, 1, 0, 16'h0000, 5'd4);
    chk("pop_load_dout", dout, 16'h0001);
    step(0, 0, 0, 0, 1, 16'h0000, 5'd0);
    chk("temp1_a", alu_out, 16'hFFFF);
    opcode = 5'd1;  #1; chk("temp2_b", alu_out, 16'h0001);
    opcode = 5'd4;  #1; chk("wrap_add", alu_out, 16'h0000);
    opcode = 5'd5;  #1; chk("wrap_sub", alu_out, 16'hFFFE);
    opcode = 5'd8;  #1; chk("wrap_xor", alu_out, 16'hFFFE);
    opcode = 5'd10; #1; chk("wrap_shl", alu_out, 16'hFFFE);
    opcode = 5'd11; #1; chk("wrap_shr", alu_out, 16'h7FFF);
    opcode = 5'd9;  #1; chk("op_not", alu_out, 16'h0000);
    opcode = 5'd6;  #1; chk("op_and", alu_out, 16'h0001);
    opcode = 5'd31; #1; chk("op_undef", alu_out, 16'h0000);
    step(1, 1, 1, 0, 0, 16'h0000, 5'd11);
    chk("alu_push_shr", tos, 16'h7FFF);

    step(1, 1, 0, 0, 0, 16'hAAAA, 5'd4);
    step(1, 1, 0, 0, 0, 16'hBBBB, 5'd4);
    step(1, 0, 0, 0, 0, 16'h0000, 5'd4);
    chk("pre_rst_dout", dout, 16'hBBBB);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_dout", dout, 16'h0000);
    chk("mid_rst_tos", tos, 16'h0000);
    chk("mid_rst_empty", {15'd0, empty}, 16'h0001);
    chk("mid_rst_alu", alu_out, 16'h0000);
    #1 reset = 1'b1;
    step(1, 1, 0, 0, 0, 16'hC0DE, 5'd4);
    chk("post_rst_tos", tos, 16'hC0DE);
    step(0, 0, 0, 0, 0, 16'h0000, 5'd4);
    step(0, 0, 0, 0, 0, 16'h0000, 5'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
